// File: rtl/pa_clk_pkg.sv
// rtl/pa_clk_pkg.sv - shared encodings and defaults for the CPU low-power-mode sequencer
package pa_clk_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_GATE  = 3'd2,
    ST_SLEEP = 3'd3,
    ST_WAKE  = 3'd4
  } lpmd_state_e;

  localparam logic [1:0] LPMD_RUN   = 2'b00;
  localparam logic [1:0] LPMD_ENTER = 2'b01;
  localparam logic [1:0] LPMD_SLEEP = 2'b10;
  localparam logic [1:0] LPMD_WAKE  = 2'b11;

  localparam int IDLE_CYC_DEF = 4;
  localparam int WAKE_DLY_DEF = 2;
  localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/pa_clk_lpmd_cnt.sv
// rtl/pa_clk_lpmd_cnt.sv - loadable saturating down-counter shared by drain and settle phases
module pa_clk_lpmd_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // load wins over dec so a reload on a busy cycle always restarts the window
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pa_clk_lpmd_ctrl.sv
// rtl/pa_clk_lpmd_ctrl.sv - WFI sleep / wake sequencer owning the CPU clock enable
module pa_clk_lpmd_ctrl
  import pa_clk_pkg::*;
#(
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int WAKE_DLY = WAKE_DLY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic       sleep_req,
  input  logic       biu_idle,
  input  logic       wake_evt,
  input  logic       dbg_req,
  input  logic       clk_en_f,
  output logic       clk_en,
  output logic       sleep_ack,
  output logic       wake_done,
  output logic [1:0] lpmd_st
);

  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DLY);

  lpmd_state_e      state;
  logic             armed;
  logic             wk;
  logic             enter;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign wk    = wake_evt | dbg_req;
  assign enter = sleep_req & armed & ~wk;

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = IDLE_LD;
    cnt_dec  = 1'b0;
    case (state)
      ST_RUN: begin
        cnt_load = enter;
      end
      ST_DRAIN: begin
        if (!(wk || !sleep_req)) begin
          if (!biu_idle) begin
            cnt_load = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_GATE, ST_SLEEP: begin
        cnt_load = wk;
        cnt_val  = WAKE_LD;
      end
      ST_WAKE: begin
        cnt_dec = 1'b1;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  pa_clk_lpmd_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .load           (cnt_load),
    .load_val       (cnt_val),
    .dec            (cnt_dec),
    .zero           (cnt_zero)
  );

  // armed re-arms only after sleep_req is seen low, so a held request cannot loop back into sleep
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state     <= ST_RUN;
      clk_en    <= 1'b1;
      sleep_ack <= 1'b0;
      wake_done <= 1'b0;
      lpmd_st   <= LPMD_RUN;
      armed     <= 1'b1;
    end else begin
      wake_done <= 1'b0;
      if (!sleep_req) begin
        armed <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (enter) begin
            state   <= ST_DRAIN;
            lpmd_st <= LPMD_ENTER;
            armed   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (wk || !sleep_req) begin
            state   <= ST_RUN;
            lpmd_st <= LPMD_RUN;
          end else if (biu_idle && cnt_zero) begin
            state  <= ST_GATE;
            clk_en <= 1'b0;
          end
        end
        ST_GATE: begin
          if (wk) begin
            state   <= ST_WAKE;
            clk_en  <= 1'b1;
            lpmd_st <= LPMD_WAKE;
          end else if (!clk_en_f) begin
            state     <= ST_SLEEP;
            sleep_ack <= 1'b1;
            lpmd_st   <= LPMD_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (wk) begin
            state     <= ST_WAKE;
            clk_en    <= 1'b1;
            sleep_ack <= 1'b0;
            lpmd_st   <= LPMD_WAKE;
          end
        end
        ST_WAKE: begin
          if (cnt_zero && clk_en_f) begin
            state     <= ST_RUN;
            wake_done <= 1'b1;
            lpmd_st   <= LPMD_RUN;
          end
        end
        default: begin
          state     <= ST_RUN;
          clk_en    <= 1'b1;
          sleep_ack <= 1'b0;
          lpmd_st   <= LPMD_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pa_clk_lpmd_ctrl.sv
// tb/tb_pa_clk_lpmd_ctrl.sv - self-checking bench for the low-power-mode sequencer
module tb_pa_clk_lpmd_ctrl;

  localparam int IDLE_CYC = 4;
  localparam int WAKE_DLY = 2;

  logic       forever_cpuclk = 1'b0;
  logic       cpurst, sleep_req, biu_idle, wake_evt, dbg_req, clk_en_f;
  logic       clk_en, sleep_ack, wake_done;
  logic [1:0] lpmd_st;

  logic fb_q;
  logic fb_hold;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model: 0 run, 1 drain, 2 gate, 3 sleep, 4 wake
  int m_mode, m_streak, m_age;
  bit m_armed, m_done;

  typedef struct {
    logic       sr;
    logic       we;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [16];

  always #5 forever_cpuclk = ~forever_cpuclk;

  // clock-top stand-in: registered copy of clk_en, optionally frozen
  always @(posedge forever_cpuclk) begin
    if (cpurst) fb_q <= 1'b1;
    else if (!fb_hold) fb_q <= clk_en;
  end
  assign clk_en_f = fb_q;

  pa_clk_lpmd_ctrl #(
    .IDLE_CYC (IDLE_CYC),
    .WAKE_DLY (WAKE_DLY),
    .CNT_W    (4)
  ) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .sleep_req      (sleep_req),
    .biu_idle       (biu_idle),
    .wake_evt       (wake_evt),
    .dbg_req        (dbg_req),
    .clk_en_f       (clk_en_f),
    .clk_en         (clk_en),
    .sleep_ack      (sleep_ack),
    .wake_done      (wake_done),
    .lpmd_st        (lpmd_st)
  );

  function automatic logic [4:0] m_out();
    logic       ce, ack;
    logic [1:0] st;
    ce  = !(m_mode == 2 || m_mode == 3);
    ack = (m_mode == 3);
    case (m_mode)
      0:       st = 2'b00;
      1, 2:    st = 2'b01;
      3:       st = 2'b10;
      default: st = 2'b11;
    endcase
    return {ce, ack, m_done, st};
  endfunction

  task automatic model_edge();
    bit wk;
    wk = wake_evt || dbg_req;
    if (cpurst) begin
      m_mode = 0; m_armed = 1; m_done = 0; m_streak = 0; m_age = 0;
      return;
    end
    m_done = 0;
    case (m_mode)
      0: if (sleep_req && m_armed && !wk) begin m_mode = 1; m_streak = 0; m_armed = 0; end
      1: begin
        if (wk || !sleep_req) m_mode = 0;
        else if (!biu_idle) m_streak = 0;
        else if (m_streak + 1 >= IDLE_CYC + 1) m_mode = 2;
        else m_streak++;
      end
      2: begin
        if (wk) begin m_mode = 4; m_age = 0; end
        else if (!clk_en_f) m_mode = 3;
      end
      3: if (wk) begin m_mode = 4; m_age = 0; end
      default: begin
        if (m_age >= WAKE_DLY && clk_en_f) begin m_mode = 0; m_done = 1; end
        else if (m_age < WAKE_DLY) m_age++;
      end
    endcase
    if (!sleep_req) m_armed = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sr, input logic bi, input logic we, input logic dr, input logic rs);
    sleep_req = sr; biu_idle = bi; wake_evt = we; dbg_req = dr; cpurst = rs;
    model_edge();
    @(posedge forever_cpuclk);
    #1;
    chk("model", {27'd0, clk_en, sleep_ack, wake_done, lpmd_st}, {27'd0, m_out()});
    if (sleep_ack) chk("inv_ack_gated", {30'd0, clk_en, clk_en_f}, 32'd0);
  endtask

  task automatic do_reset();
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
  endtask

  initial begin
    fb_hold = 1'b0;
    sleep_req = 0; biu_idle = 1; wake_evt = 0; dbg_req = 0; cpurst = 1;

    for (int i = 0; i < 16; i++) begin
      tbl[i].sr = 1'b1; tbl[i].we = 1'b0;
    end
    for (int i = 0; i < 5; i++) tbl[i].exp = 5'b10001;
    tbl[5].exp  = 5'b00001;
    tbl[6].exp  = 5'b00001;
    tbl[7].exp  = 5'b01010;
    tbl[8].exp  = 5'b01010;
    tbl[9].we   = 1'b1;
    tbl[9].exp  = 5'b10011;
    tbl[10].exp = 5'b10011;
    tbl[11].exp = 5'b10011;
    tbl[12].exp = 5'b10100;
    tbl[13].exp = 5'b10000;
    tbl[14].sr  = 1'b0;
    tbl[14].exp = 5'b10000;
    tbl[15].exp = 5'b10001;

    // reset state, then normal sleep, wake, and re-arm by dropping sleep_req
    do_reset();
    chk("reset_state", {27'd0, clk_en, sleep_ack, wake_done, lpmd_st}, 32'b10000);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].sr, 1, tbl[i].we, 0, 0);
      chk($sformatf("tbl_%0d", i), {27'd0, clk_en, sleep_ack, wake_done, lpmd_st}, {27'd0, tbl[i].exp});
    end

    // bus busy during drain restarts the idle window
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0, 0, 0);
      chk($sformatf("busy_gate_%0d", k), {31'd0, clk_en}, (k == 5) ? 32'd0 : 32'd1);
    end

    // stuck feedback holds GATE, then a wake event escapes without sleep_ack
    fb_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0, 0);
      chk("stuck_gate", {29'd0, clk_en, sleep_ack, lpmd_st}, 32'b0001);
    end
    step(1, 1, 1, 0, 0);
    chk("gate_wake", {29'd0, clk_en, sleep_ack, lpmd_st}, 32'b1011);
    fb_hold = 1'b0;
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
    chk("gate_wake_back_run", {30'd0, lpmd_st}, 32'd0);

    // debug abort in drain never drops clk_en, and held sleep_req stays out
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    chk("dbg_abort", {29'd0, clk_en, sleep_ack, lpmd_st}, 32'b1000);
    step(1, 1, 0, 0, 0);
    chk("dbg_no_reentry", {30'd0, lpmd_st}, 32'd0);

    // reset while asleep
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 0);
    chk("pre_reset_sleep", {30'd0, sleep_ack, clk_en}, 32'b10);
    step(1, 1, 0, 0, 1);
    chk("reset_mid_sleep", {27'd0, clk_en, sleep_ack, wake_done, lpmd_st}, 32'b10000);

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if (fb_hold) fb_hold = ($urandom_range(0, 3) != 0);
      else         fb_hold = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
